// File: rtl/vga_pattern_sequencer.sv
// VGA raster timing generator with a frame-synchronous test-pattern selector.
// Pattern changes (manual advance or auto rotation) only ever land on a frame
// boundary, so the monitor never sees a frame split between two patterns.
module vga_pattern_sequencer #(
  parameter int H_ACTIVE           = 1280,
  parameter int H_FP               = 48,
  parameter int H_SYNC             = 112,
  parameter int H_BP               = 248,
  parameter int V_ACTIVE           = 960,
  parameter int V_FP               = 1,
  parameter int V_SYNC             = 3,
  parameter int V_BP               = 38,
  parameter int FRAMES_PER_PATTERN = 60,
  parameter int NUM_PATTERNS       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        auto_mode,
  input  logic        advance,
  output logic [11:0] pixel_x,
  output logic [11:0] pixel_y,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [1:0]  pattern_sel,
  output logic [7:0]  frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT   = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT   = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END  = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [1:0]  PAT_MAX = 2'(NUM_PATTERNS - 1);
  localparam logic [8:0]  FPP     = 9'(FRAMES_PER_PATTERN);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_x;
  logic [11:0] r_y;
  logic [1:0]  r_pat;
  logic [7:0]  r_fc;
  logic        r_pending;

  logic w_run;
  logic w_leave;
  logic w_x_last;
  logic w_y_last;
  logic w_wrap;
  logic w_auto_due;
  logic w_step;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state: enable level alone moves between IDLE and RUN
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable)  w_state_nxt = S_RUN;
      S_RUN:   if (!enable) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: zero-latency decodes of the current raster position
  always_comb begin
    w_run       = (r_state == S_RUN);
    video_on    = w_run && (r_x < H_ACT) && (r_y < V_ACT);
    hsync       = w_run && (r_x >= HS_BEG) && (r_x < HS_END);
    vsync       = w_run && (r_y >= VS_BEG) && (r_y < VS_END);
    frame_start = w_run && (r_x == 12'd0) && (r_y == 12'd0);
  end

  assign w_leave    = w_run && !enable;
  assign w_x_last   = (r_x == H_LAST);
  assign w_y_last   = (r_y == V_LAST);
  assign w_wrap     = w_run && w_x_last && w_y_last;
  // Auto rotation is due when the frame now ending completes the quota
  assign w_auto_due = auto_mode && (({1'b0, r_fc} + 9'd1) >= FPP);
  assign w_step     = w_wrap && (r_pending || w_auto_due);

  // Raster counters: run only in RUN, parked at the origin otherwise
  always_ff @(posedge clk) begin
    if (reset || !w_run || w_leave) begin
      r_x <= 12'd0;
      r_y <= 12'd0;
    end else if (w_x_last) begin
      r_x <= 12'd0;
      r_y <= w_y_last ? 12'd0 : r_y + 12'd1;
    end else begin
      r_x <= r_x + 12'd1;
    end
  end

  // Pattern index: steps at most once, and only on a frame wrap
  always_ff @(posedge clk) begin
    if (reset)       r_pat <= 2'd0;
    else if (w_step) r_pat <= (r_pat == PAT_MAX) ? 2'd0 : r_pat + 2'd1;
  end

  // Frames-on-this-pattern counter, saturating; cleared on step or stop
  always_ff @(posedge clk) begin
    if (reset || !w_run || w_leave) r_fc <= 8'd0;
    else if (w_step)                r_fc <= 8'd0;
    else if (w_wrap)                r_fc <= (r_fc == 8'hFF) ? r_fc : r_fc + 8'd1;
  end

  // Pending advance: a pulse on the wrap cycle survives to the next wrap
  always_ff @(posedge clk) begin
    if (reset || !w_run || w_leave) r_pending <= 1'b0;
    else if (advance)               r_pending <= 1'b1;
    else if (w_wrap)                r_pending <= 1'b0;
  end

  assign pixel_x     = r_x;
  assign pixel_y     = r_y;
  assign pattern_sel = r_pat;
  assign frame_count = r_fc;

endmodule
